uart_cmd_assembler: RTL and testbench

Sits directly downstream of the UART receiver. It consumes received bytes (cmd/rdy), acknowledges each with a clear-ready strobe, and assembles two consecutive bytes, high byte first, into a 16-bit command word for the command processor. An inter-byte timeout recovers framing when a byte is lost. An overrun flag reports a command that was replaced before it was consumed.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_cmd_assembler.sv | 94 +++++++++
 tb/tb_uart_cmd_assembler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the command assembler state type.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } asm_state_t;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 19200;
    localparam int unsigned BAUD_CYC = 2604;

    // Four 10-bit frames of slack between bytes, rounded up to 104200 cycles.
    localparam int unsigned TIMEOUT_CYC_DFLT = 40 * BAUD_CYC + 40;

endpackage

// File: rtl/uart_cmd_assembler.sv
// Pairs received UART bytes (high first) into 16-bit commands, with an
// inter-byte timeout that drops a stranded high byte and an overrun pulse.
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        sync_err,
    output logic        ovr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [0:0] ST_IDLE     = 1'(IDLE);
    localparam logic [0:0] ST_WAIT_LOW = 1'(WAIT_LOW);

    logic [0:0]       state,    state_d;
    logic [7:0]       high,     high_d;
    logic [CNT_W-1:0] cnt,      cnt_d;
    logic [15:0]      cmd_d;
    logic             cmd_rdy_d;
    logic             sync_err_d;
    logic             ovr_d;

    // Every presented byte is acknowledged immediately; held low while in reset.
    assign clr_rx_rdy = rx_rdy & rst_n;

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d    = state;
        high_d     = high;
        cnt_d      = cnt;
        cmd_d      = cmd;
        cmd_rdy_d  = cmd_rdy & ~clr_cmd_rdy;
        sync_err_d = 1'b0;
        ovr_d      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    high_d  = rx_byte;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                // A byte arriving on the expiry edge still completes the command.
                if (rx_rdy) begin
                    cmd_d     = {high, rx_byte};
                    cmd_rdy_d = 1'b1;
                    ovr_d     = cmd_rdy & ~clr_cmd_rdy;
                    state_d   = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            high     <= '0;
            cnt      <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            sync_err <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_d;
            high     <= high_d;
            cnt      <= cnt_d;
            cmd      <= cmd_d;
            cmd_rdy  <= cmd_rdy_d;
            sync_err <= sync_err_d;
            ovr      <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a short timeout.
module tb_uart_cmd_assembler;

    localparam int unsigned T = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        sync_err;
    logic        ovr;

    uart_cmd_assembler #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte     (rx_byte),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .sync_err    (sync_err),
        .ovr         (ovr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_clr = 0;

    // Count receiver acknowledges (one negedge per presented byte).
    always @(negedge clk) begin
        if (clr_rx_rdy) n_clr <= n_clr + 1;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        bit          pre_clr;
        bit          clr_at_low;
        int          gap;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Present one byte like the receiver does; it drops rdy after the consuming edge.
    task automatic send(input logic [7:0] b, input logic clr_same);
        rx_byte = b;
        rx_rdy = 1'b1;
        clr_cmd_rdy = clr_same;
        #1;
        check("clr_rx_rdy_high", 32'(clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        rx_byte = 8'($urandom);
        #1;
        check("clr_rx_rdy_low", 32'(clr_rx_rdy), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int clr0;
        int se_cnt;
        int se_pos;

        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 0,   16'hA53C, 1'b1, 1'b0};
        vecs[1] = '{8'h11, 8'h22, 1'b1, 1'b0, 3,   16'h1122, 1'b1, 1'b0};
        vecs[2] = '{8'h33, 8'h44, 1'b0, 1'b0, 0,   16'h3344, 1'b1, 1'b1};
        vecs[3] = '{8'hEF, 8'hBE, 1'b0, 1'b1, 5,   16'hEFBE, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, 8'hA5, 1'b1, 1'b0, T-1, 16'h5AA5, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 8'h5A, 1'b0, 1'b0, 0,   16'hC35A, 1'b1, 1'b1};

        // Reset values, and acknowledge held low during reset.
        rx_rdy = 1'b1;
        #1;
        check("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);

        // Table of byte pairs.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre_clr) begin
                pulse_clr();
                check($sformatf("v%0d_pre_clr_rdy", i), 32'(cmd_rdy), 32'd0);
            end
            clr0 = n_clr;
            send(vecs[i].hi, 1'b0);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
            send(vecs[i].lo, vecs[i].clr_at_low);
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_cmd_rdy", i), 32'(cmd_rdy), 32'(vecs[i].exp_rdy));
            check($sformatf("v%0d_ovr", i), 32'(ovr), 32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_sync_err", i), 32'(sync_err), 32'd0);
            check($sformatf("v%0d_clr_count", i), 32'(n_clr - clr0), 32'd2);
            idle(1);
            check($sformatf("v%0d_ovr_fall", i), 32'(ovr), 32'd0);
            check($sformatf("v%0d_sync_err_after", i), 32'(sync_err), 32'd0);
        end

        // Consumer acknowledge clears cmd_rdy but keeps cmd.
        pulse_clr();
        check("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("ack_cmd_hold", 32'(cmd), 32'hC35A);

        // Lone high byte times out after T idle cycles.
        send(8'h12, 1'b0);
        se_cnt = 0;
        se_pos = 0;
        for (int k = 1; k <= T + 5; k++) begin
            @(posedge clk);
            #1;
            if (sync_err) begin
                se_cnt++;
                se_pos = k;
            end
        end
        check("to_sync_err_count", 32'(se_cnt), 32'd1);
        check("to_sync_err_pos", 32'(se_pos), 32'(T));
        check("to_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("to_cmd_hold", 32'(cmd), 32'hC35A);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        check("to_resync_cmd", 32'(cmd), 32'h3456);
        check("to_resync_rdy", 32'(cmd_rdy), 32'd1);
        check("to_resync_ovr", 32'(ovr), 32'd0);

        // Reset while holding a high byte; next byte must be treated as high.
        send(8'h99, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        rx_rdy = 1'b1;
        #1;
        check("mid_rst_cmd", 32'(cmd), 32'h0);
        check("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("mid_rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_sync_err", 32'(sync_err), 32'd0);
        check("mid_rst_ovr", 32'(ovr), 32'd0);
        #2;
        rst_n = 1'b1;
        idle(1);
        send(8'h00, 1'b0);
        check("post_rst_no_cmd", 32'(cmd_rdy), 32'd0);
        send(8'hFF, 1'b0);
        check("post_rst_cmd", 32'(cmd), 32'h00FF);
        check("post_rst_rdy", 32'(cmd_rdy), 32'd1);
        check("post_rst_ovr", 32'(ovr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
